// File: rtl/fp_issue_sequencer_if.sv
// rtl/fp_issue_sequencer_if.sv - issue, register-file and FPU control bundle for the FP sequencer
interface fp_issue_sequencer_if;
  logic       issue_valid;
  logic       issue_ready;
  logic [1:0] funct;
  logic [4:0] fs;
  logic [4:0] ft;
  logic [4:0] fd;
  logic       stall;
  logic       busy;
  logic [4:0] fpr_ra1;
  logic [4:0] fpr_ra2;
  logic       fpu_start;
  logic [1:0] fpu_op;
  logic       fpu_exc;
  logic       fpr_we;
  logic [4:0] fpr_wa;
  logic       exc_flag;
  logic       exc_clear;

  modport master (
    output issue_valid, funct, fs, ft, fd, fpu_exc, exc_clear,
    input  issue_ready, stall, busy, fpr_ra1, fpr_ra2, fpu_start, fpu_op,
           fpr_we, fpr_wa, exc_flag
  );

  modport slave (
    input  issue_valid, funct, fs, ft, fd, fpu_exc, exc_clear,
    output issue_ready, stall, busy, fpr_ra1, fpr_ra2, fpu_start, fpu_op,
           fpr_we, fpr_wa, exc_flag
  );
endinterface

// File: rtl/fp_issue_sequencer.sv
// rtl/fp_issue_sequencer.sv - one-at-a-time FP issue: read, fixed-latency execute, write back
module fp_issue_sequencer #(
  parameter int ADD_LAT = 3,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 12,
  parameter int CNT_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  fp_issue_sequencer_if.slave  sif
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] EXEC = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lat_m1;
  logic [1:0]       funct_q;
  logic [4:0]       ra1_q;
  logic [4:0]       ra2_q;
  logic [4:0]       fd_q;
  logic             exc_q;
  logic             accept;

  assign sif.issue_ready = (state == IDLE) || (state == WB);
  assign accept          = sif.issue_valid && sif.issue_ready;
  assign sif.stall       = sif.issue_valid && !sif.issue_ready;
  assign sif.busy        = (state != IDLE);
  assign sif.fpu_start   = (state == READ);
  assign sif.fpu_op      = funct_q;
  assign sif.fpr_ra1     = ra1_q;
  assign sif.fpr_ra2     = ra2_q;
  assign sif.fpr_we      = (state == WB);
  assign sif.fpr_wa      = (state == WB) ? fd_q : 5'd0;
  assign sif.exc_flag    = exc_q;

  always_comb begin
    lat_m1 = CNT_W'(ADD_LAT - 1);
    case (funct_q)
      2'b10:   lat_m1 = CNT_W'(MUL_LAT - 1);
      2'b11:   lat_m1 = CNT_W'(DIV_LAT - 1);
      default: lat_m1 = CNT_W'(ADD_LAT - 1);
    endcase
  end

  // Read addresses are captured at accept so they are already valid in the READ cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      funct_q <= 2'd0;
      ra1_q   <= 5'd0;
      ra2_q   <= 5'd0;
      fd_q    <= 5'd0;
    end else begin
      if (accept) begin
        funct_q <= sif.funct;
        ra1_q   <= sif.fs;
        ra2_q   <= sif.ft;
        fd_q    <= sif.fd;
      end
      case (state)
        IDLE: if (accept) state <= READ;
        READ: begin
          cnt   <= lat_m1;
          state <= EXEC;
        end
        EXEC: begin
          if (cnt == '0) state <= WB;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: state <= accept ? READ : IDLE;
      endcase
    end
  end

  // A new exception in write-back wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_q <= 1'b0;
    end else if ((state == WB) && sif.fpu_exc) begin
      exc_q <= 1'b1;
    end else if (sif.exc_clear) begin
      exc_q <= 1'b0;
    end
  end
endmodule

// File: doc/fp_issue_sequencer.md
# fp_issue_sequencer

Sequences the multi-cycle floating-point datapath of the MIPS_FPU CPU. It accepts one FP arithmetic instruction at a time from the decode stage and drives the FP register-file read addresses. It starts the FPU, counts out the operation's fixed latency, then writes the result back. Issue is stalled while an operation is in flight. Back-to-back issue is allowed in the write-back cycle.

## Interface
Parameters:
- ADD_LAT, 3, FPU cycles for add/sub (>=1)
- MUL_LAT, 4, FPU cycles for mul (>=1)
- DIV_LAT, 12, FPU cycles for div (>=1)
- CNT_W, 4, latency counter width; must hold max(LAT)-1

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- issue_valid  in  1  decode presents an FP instruction
- issue_ready  out  1  sequencer can accept this cycle
- funct  in  2  00 add, 01 sub, 10 mul, 11 div
- fs, ft, fd  in  5 each  source/destination FP register numbers
- stall  out  1  issue_valid & ~issue_ready; freezes PC/decode
- busy  out  1  state != IDLE
- fpr_ra1, fpr_ra2  out  5 each  FP regfile read addresses
- fpu_start  out  1  one-cycle start pulse to FPU
- fpu_op  out  2  latched funct to FPU
- fpu_exc  in  1  FPU exception (div-by-zero/overflow), valid in WB
- fpr_we  out  1  FP regfile write enable
- fpr_wa  out  5  FP regfile write address
- exc_flag  out  1  sticky exception flag
- exc_clear  in  1  clears exc_flag

## Operation
- States: IDLE, READ, EXEC, WB.
- IDLE: issue_ready=1. On issue_valid, latch funct/fs/ft/fd, go READ.
- READ (1 cycle): fpr_ra1=fs_q, fpr_ra2=ft_q, fpu_start=1, fpu_op=funct_q. FPU captures operands at the end of this cycle. Load counter with LAT-1 and go EXEC.
- LAT selection: funct 00/01 -> ADD_LAT; 10 -> MUL_LAT; 11 -> DIV_LAT.
- EXEC: decrement the counter each cycle. When counter==0, go WB. EXEC therefore lasts exactly LAT cycles.
- WB (1 cycle): fpr_we=1, fpr_wa=fd_q. Sample fpu_exc; if 1, set exc_flag. issue_ready=1.
  - issue_valid in WB: latch the new instruction, go READ.
  - Otherwise go IDLE.
- The regfile write commits at the WB clock edge, so a dependent instruction issued in WB reads the new value in its READ cycle. No forwarding is needed.
- fd=0 is written normally; $f0 is not hardwired.
- exc_flag: set has priority over exc_clear in the same cycle.
- fpr_ra1/ra2 hold their last-driven values outside READ. fpr_wa is 0 outside WB. fpu_op holds funct_q.

## Timing
- Reset (async, immediate) values:
  - State IDLE; counter 0.
  - Latched fields 0.
  - fpu_start, fpr_we, fpr_wa, fpr_ra1, fpr_ra2, fpu_op, exc_flag, busy, stall all 0.
  - issue_ready 1.
- Reset mid-operation: the in-flight instruction is dropped and no fpr_we pulse occurs. exc_flag is cleared.
- Latency: accept at edge of cycle 0 -> fpu_start in cycle 1 -> fpr_we in cycle LAT+2.
- Throughput: one instruction per LAT+2 cycles.
- issue_ready and stall are combinational from state and issue_valid. All other outputs are registered or pure state decodes; no input-to-output paths except stall.
- issue_valid held low: the sequencer never leaves IDLE. There are no spurious pulses.

## Test plan
- Single add, ADD_LAT=3:
  - Stimulus: issue fs=1, ft=2, fd=3 at cycle 0.
  - Response: cycle 1 fpu_start=1, ra1=1, ra2=2, op=00. Cycle 5 fpr_we=1, wa=3. issue_ready=0 in cycles 1–4. stall=1 if issue_valid held.
- Latency per op:
  - mul -> fpr_we at cycle 6.
  - div -> fpr_we at cycle 14.
  - Exactly one fpu_start and one fpr_we per instruction.
- Back-to-back dependent pair:
  - Stimulus: add fd=4; then mul fs=4, ft=4, fd=5 presented and accepted in the add's WB (cycle 5).
  - Response: mul READ at cycle 6 with ra1=ra2=4. Mul fpr_we at cycle 11, wa=5.
- Reset in EXEC:
  - Stimulus: assert reset at cycle 8 of a div.
  - Response: all outputs immediately at reset values. No fpr_we after release. A new add completes normally.
- Exception:
  - Stimulus: fpu_exc=1 in WB of a div.
  - Response: exc_flag=1 from the next cycle and held across later ops. exc_clear and a new exception in the same cycle leave exc_flag=1. exc_clear alone clears it.
